hd_ctrl_seq: RTL and testbench
==============================

Name: hd_ctrl_seq

Overview:
- Clocked, parametrised hardwired controller for the teaching CPU datapath.
- Owns its beat sequencer (W1/W2/W3), the console-mode state (ST0 plus a register pass counter) and the instruction decode.
- Generalises the controller to NREG registers, carries operand register fields into the decode, and adds START-driven single stepping.
- Drives the ALU, bus, register-file, PC/AR and memory strobes of the datapath.

Parameters:
- NREG, 4: register-file depth; even, 2..16.
- RSEL_W, 2: register select width; must equal clog2(NREG).
- IR_W, 8: instruction width, equal to 4+2*RSEL_W. Layout: opcode IR[IR_W-1:IR_W-4], RD next, RS lowest.

Ports:
- CLK  in  1  system clock; each rising edge is one beat.
- CLR  in  1  asynchronous active-high reset.
- START  in  1  one-cycle pulse (QD button); resumes the sequencer from IDLE.
- SW  in  3  console mode: 000 run, 001 write mem, 010 read mem, 011 read regs, 100 write regs.
- IR  in  IR_W  current instruction.
- C, Z  in  1 each  ALU carry and zero flags.
- W  out  3  one-hot beat {W3,W2,W1}; 000 when IDLE.
- ST0  out  1  second-phase flag.
- BUSY  out  1  high when not IDLE.
- RD_SEL, RS_SEL  out  RSEL_W each  register selects; the console value applies when SELCTL=1.
- S  out  4  ALU function select.
- M, CIN, ABUS, SBUS, MBUS, DRW, LDC, LDZ, PCINC, LPC, PCADD, LAR, ARINC, MEMW, LIR, SELCTL, STOP, SHORT, LONG  out  1 each  datapath strobes.

Behaviour:
- Sequencer states: IDLE, B1, B2, B3. W is the one-hot image of the state.
- CLR asserted: state IDLE, ST0=0, RIDX=0, MODE=000, and every output 0. All outputs are combinational decodes of the state, so they are 0 in IDLE.
- START in IDLE: SW is latched into MODE, then the next edge enters B1.
  - If the latched SW differs from the previous MODE, ST0 and RIDX clear on that same edge.
  - START is ignored outside IDLE. SW changes are ignored outside IDLE.
- B1→B2 normally. B1→B1 if SHORT=1. B2→B3 if LONG=1, else B2→B1. B3→B1.
- STOP=1 in a beat: the next state is IDLE instead, and any ST0/RIDX update of that beat still commits.
- Mode 001 (write mem): B1 drives SBUS, SELCTL, SHORT, STOP.
  - ST0=0: LAR, then set ST0.
  - ST0=1: MEMW and ARINC.
- Mode 010 (read mem): same as 001 with MBUS and ARINC in place of MEMW when ST0=1.
- Mode 011 (read regs): beats B1 and B2, both with SELCTL and STOP.
  - Each pass shows RD_SEL=RIDX and RS_SEL=RIDX+1.
  - RIDX advances by 2 per pass and wraps to 0 after NREG-2.
- Mode 100 (write regs): B1 and B2 both drive SBUS, SELCTL, DRW, STOP.
  - B1 writes register RIDX; B2 writes register RIDX+1.
  - RIDX+=2 per pass and wraps to 0. ST0 = (RIDX != 0) after each pass.
- Mode 000, ST0=0: B1 drives LPC, SBUS, SHORT, STOP; sets ST0.
- Mode 000, ST0=1: B1 drives LIR and PCINC (fetch). B2/B3 by opcode:
  - ADD 0001: S=1001, CIN, ABUS, DRW, LDZ, LDC.
  - SUB 0010: S=0110, ABUS, DRW, LDZ, LDC.
  - AND 0011: M, S=1011, ABUS, DRW, LDZ.
  - INC 0100: S=0000, ABUS, DRW, LDZ, LDC.
  - LD 0101: B2 M, S=1010, ABUS, LAR, LONG; B3 DRW, MBUS.
  - ST 0110: B2 M, S=1111, ABUS, LAR, LONG; B3 M, S=1010, ABUS, MEMW.
  - JC 0111: PCADD in B2 iff C. JZ 1000: PCADD in B2 iff Z.
  - JMP 1001: M, S=1111, ABUS, LPC.
  - STP 1110: STOP in B2.
  - Other opcodes: no strobes (NOP).
  - RD_SEL and RS_SEL come from the IR fields; SELCTL=0.
- CLR mid-beat: immediate return to IDLE with all outputs 0; no partial strobe survives.

Optional Feature:
- Macro EXT_ISA_EN defined:
  - OUT 1010: M, S=1010, ABUS.
  - XOR 1011: M, S=0110, ABUS, DRW, LDZ.
  - OR 1100: M, S=1110, ABUS, DRW, LDZ.
- Macro undefined: opcodes 1010–1100 decode as NOP.

Test Plan:
- CLR pulse, then idle 5 cycles → W=000, BUSY=0, ST0=0, every strobe 0.
- SW=100, NREG=4, four START pulses → DRW writes regs 0,1,2,3,0,1,2,3 in order; RIDX wraps to 0; sequencer in IDLE after each pass.
- SW=001, START, START → pass 1: B1 with LAR=1 and ST0 set; pass 2: MEMW=1 and ARINC=1, SHORT=1.
- SW=000, START (PC load), START, IR=0101_01_10 → B1 LIR/PCINC, B2 LAR/LONG, B3 DRW/MBUS with RD_SEL=01, then back to B1.
- IR=0111 with C=0, then C=1 → PCADD=0, then PCADD=1 in B2; IR=1110 → STOP in B2, sequencer holds in IDLE until START.
- Switch SW from 100 to 011 with RIDX=2, then START → RIDX and ST0 cleared; RD_SEL=0 and RS_SEL=1 shown.

Source files
------------

// File: rtl/hd_ctrl_seq.sv
// Purpose : hardwired controller for the teaching CPU; beat sequencer, console modes, decode.
// Latency : strobes are combinational from the current beat; the state advances every CLK edge.
// Backpres: none; START is honoured only in IDLE, and STOP (or end of pass) returns to IDLE.
//
// Ports: CLK/CLR clock and async active-high reset; START resume pulse; SW console mode;
//        IR instruction; C/Z ALU flags; W one-hot beat; ST0 phase flag; BUSY not-IDLE;
//        RD_SEL/RS_SEL register selects; S/M/CIN ALU control; remaining outputs are datapath strobes.
// Optional: define EXT_ISA_EN to decode OUT/XOR/OR (opcodes 1010-1100); otherwise they are NOPs.
module hd_ctrl_seq #(
    parameter int NREG   = 4,
    parameter int RSEL_W = 2,
    parameter int IR_W   = 8
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              START,
    input  logic [2:0]        SW,
    input  logic [IR_W-1:0]   IR,
    input  logic              C,
    input  logic              Z,
    output logic [2:0]        W,
    output logic              ST0,
    output logic              BUSY,
    output logic [RSEL_W-1:0] RD_SEL,
    output logic [RSEL_W-1:0] RS_SEL,
    output logic [3:0]        S,
    output logic M, CIN, ABUS, SBUS, MBUS, DRW, LDC, LDZ, PCINC, LPC, PCADD,
    output logic LAR, ARINC, MEMW, LIR, SELCTL, STOP, SHORT, LONG
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_B1   = 2'd1;
    localparam logic [1:0] S_B2   = 2'd2;
    localparam logic [1:0] S_B3   = 2'd3;

    localparam logic [RSEL_W-1:0] RIDX_LAST = RSEL_W'(NREG - 2);

    logic [1:0]        state, nxt_state;
    logic [2:0]        mode;
    logic              st0, nxt_st0;
    logic [RSEL_W-1:0] ridx, nxt_ridx, ridx_p1, ridx_adv;
    logic              term, stop_term;
    logic [3:0]        opcode;

    assign opcode   = IR[IR_W-1 -: 4];
    assign ridx_p1  = ridx + RSEL_W'(1);
    assign ridx_adv = (ridx >= RIDX_LAST) ? '0 : ridx + RSEL_W'(2);
    assign ST0      = st0;
    assign BUSY     = (state != S_IDLE);

    always_comb begin
        W = 3'b000; S = 4'b0000; RD_SEL = '0; RS_SEL = '0;
        M = 1'b0; CIN = 1'b0; ABUS = 1'b0; SBUS = 1'b0; MBUS = 1'b0; DRW = 1'b0;
        LDC = 1'b0; LDZ = 1'b0; PCINC = 1'b0; LPC = 1'b0; PCADD = 1'b0; LAR = 1'b0;
        ARINC = 1'b0; MEMW = 1'b0; LIR = 1'b0; SELCTL = 1'b0; STOP = 1'b0;
        SHORT = 1'b0; LONG = 1'b0;
        term = 1'b0; nxt_st0 = st0; nxt_ridx = ridx;
        case (state)
            S_B1:    W = 3'b001;
            S_B2:    W = 3'b010;
            S_B3:    W = 3'b100;
            default: W = 3'b000;
        endcase
        if (state != S_IDLE) begin
            case (mode)
                3'b001, 3'b010: begin
                    SBUS = 1'b1; SELCTL = 1'b1; SHORT = 1'b1; STOP = 1'b1;
                    if (!st0) begin
                        LAR = 1'b1; nxt_st0 = 1'b1;
                    end else begin
                        ARINC = 1'b1;
                        if (mode == 3'b001) MEMW = 1'b1;
                        else                MBUS = 1'b1;
                    end
                end
                3'b011: begin
                    SELCTL = 1'b1; STOP = 1'b1;
                    RD_SEL = ridx; RS_SEL = ridx_p1;
                    if (state == S_B2) nxt_ridx = ridx_adv;
                end
                3'b100: begin
                    SBUS = 1'b1; SELCTL = 1'b1; DRW = 1'b1; STOP = 1'b1;
                    RD_SEL = (state == S_B2) ? ridx_p1 : ridx;
                    if (state == S_B2) begin
                        nxt_ridx = ridx_adv;
                        nxt_st0  = (ridx_adv != '0);
                    end
                end
                3'b000: begin
                    if (!st0) begin
                        LPC = 1'b1; SBUS = 1'b1; SHORT = 1'b1; STOP = 1'b1;
                        nxt_st0 = 1'b1;
                    end else begin
                        RD_SEL = IR[2*RSEL_W-1 -: RSEL_W];
                        RS_SEL = IR[RSEL_W-1:0];
                        if (state == S_B1) begin
                            LIR = 1'b1; PCINC = 1'b1;
                        end else begin
                            case (opcode)
                                4'b0001: if (state == S_B2) begin
                                    S = 4'b1001; CIN = 1'b1; ABUS = 1'b1; DRW = 1'b1; LDZ = 1'b1; LDC = 1'b1;
                                end
                                4'b0010: if (state == S_B2) begin
                                    S = 4'b0110; ABUS = 1'b1; DRW = 1'b1; LDZ = 1'b1; LDC = 1'b1;
                                end
                                4'b0011: if (state == S_B2) begin
                                    M = 1'b1; S = 4'b1011; ABUS = 1'b1; DRW = 1'b1; LDZ = 1'b1;
                                end
                                4'b0100: if (state == S_B2) begin
                                    S = 4'b0000; ABUS = 1'b1; DRW = 1'b1; LDZ = 1'b1; LDC = 1'b1;
                                end
                                4'b0101: if (state == S_B2) begin
                                    M = 1'b1; S = 4'b1010; ABUS = 1'b1; LAR = 1'b1; LONG = 1'b1;
                                end else begin
                                    DRW = 1'b1; MBUS = 1'b1;
                                end
                                4'b0110: if (state == S_B2) begin
                                    M = 1'b1; S = 4'b1111; ABUS = 1'b1; LAR = 1'b1; LONG = 1'b1;
                                end else begin
                                    M = 1'b1; S = 4'b1010; ABUS = 1'b1; MEMW = 1'b1;
                                end
                                4'b0111: if (state == S_B2) PCADD = C;
                                4'b1000: if (state == S_B2) PCADD = Z;
                                4'b1001: if (state == S_B2) begin
                                    M = 1'b1; S = 4'b1111; ABUS = 1'b1; LPC = 1'b1;
                                end
                                4'b1110: if (state == S_B2) STOP = 1'b1;
`ifdef EXT_ISA_EN
                                4'b1010: if (state == S_B2) begin
                                    M = 1'b1; S = 4'b1010; ABUS = 1'b1;
                                end
                                4'b1011: if (state == S_B2) begin
                                    M = 1'b1; S = 4'b0110; ABUS = 1'b1; DRW = 1'b1; LDZ = 1'b1;
                                end
                                4'b1100: if (state == S_B2) begin
                                    M = 1'b1; S = 4'b1110; ABUS = 1'b1; DRW = 1'b1; LDZ = 1'b1;
                                end
`endif
                                default: ;
                            endcase
                        end
                    end
                end
                // Unassigned console modes have no work; end the pass quietly.
                default: term = 1'b1;
            endcase
        end
    end

    // Register passes (modes 011/100) span B1+B2: STOP lights in both beats,
    // but only the B2 beat closes the pass.
    assign stop_term = STOP && !(((mode == 3'b011) || (mode == 3'b100)) && (state == S_B1));

    always_comb begin
        nxt_state = state;
        case (state)
            S_IDLE:  if (START) nxt_state = S_B1;
            S_B1:    nxt_state = (stop_term || term) ? S_IDLE : (SHORT ? S_B1 : S_B2);
            S_B2:    nxt_state = (stop_term || term) ? S_IDLE : (LONG ? S_B3 : S_B1);
            default: nxt_state = (stop_term || term) ? S_IDLE : S_B1;
        endcase
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state <= S_IDLE;
            mode  <= 3'b000;
            st0   <= 1'b0;
            ridx  <= '0;
        end else begin
            state <= nxt_state;
            if (state == S_IDLE) begin
                if (START) begin
                    mode <= SW;
                    // A new console mode starts its own phase and register walk afresh.
                    if (SW != mode) begin
                        st0  <= 1'b0;
                        ridx <= '0;
                    end
                end
            end else begin
                st0  <= nxt_st0;
                ridx <= nxt_ridx;
            end
        end
    end

endmodule

// File: tb/tb_hd_ctrl_seq.sv
module tb_hd_ctrl_seq;

    logic       CLK, CLR, START, C, Z;
    logic [2:0] SW;
    logic [7:0] IR;
    logic [2:0] W;
    logic       ST0, BUSY;
    logic [1:0] RD_SEL, RS_SEL;
    logic [3:0] S;
    logic M, CIN, ABUS, SBUS, MBUS, DRW, LDC, LDZ, PCINC, LPC, PCADD;
    logic LAR, ARINC, MEMW, LIR, SELCTL, STOP, SHORT, LONG;

    hd_ctrl_seq #(.NREG(4), .RSEL_W(2), .IR_W(8)) dut (
        .CLK(CLK), .CLR(CLR), .START(START), .SW(SW), .IR(IR), .C(C), .Z(Z),
        .W(W), .ST0(ST0), .BUSY(BUSY), .RD_SEL(RD_SEL), .RS_SEL(RS_SEL), .S(S),
        .M(M), .CIN(CIN), .ABUS(ABUS), .SBUS(SBUS), .MBUS(MBUS), .DRW(DRW),
        .LDC(LDC), .LDZ(LDZ), .PCINC(PCINC), .LPC(LPC), .PCADD(PCADD), .LAR(LAR),
        .ARINC(ARINC), .MEMW(MEMW), .LIR(LIR), .SELCTL(SELCTL), .STOP(STOP),
        .SHORT(SHORT), .LONG(LONG)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    localparam logic [18:0] B_M     = 19'h1 << 18;
    localparam logic [18:0] B_CIN   = 19'h1 << 17;
    localparam logic [18:0] B_ABUS  = 19'h1 << 16;
    localparam logic [18:0] B_SBUS  = 19'h1 << 15;
    localparam logic [18:0] B_MBUS  = 19'h1 << 14;
    localparam logic [18:0] B_DRW   = 19'h1 << 13;
    localparam logic [18:0] B_LDC   = 19'h1 << 12;
    localparam logic [18:0] B_LDZ   = 19'h1 << 11;
    localparam logic [18:0] B_PCINC = 19'h1 << 10;
    localparam logic [18:0] B_LPC   = 19'h1 << 9;
    localparam logic [18:0] B_PCADD = 19'h1 << 8;
    localparam logic [18:0] B_LAR   = 19'h1 << 7;
    localparam logic [18:0] B_ARINC = 19'h1 << 6;
    localparam logic [18:0] B_MEMW  = 19'h1 << 5;
    localparam logic [18:0] B_LIR   = 19'h1 << 4;
    localparam logic [18:0] B_SEL   = 19'h1 << 3;
    localparam logic [18:0] B_STOP  = 19'h1 << 2;
    localparam logic [18:0] B_SHORT = 19'h1 << 1;
    localparam logic [18:0] B_LONG  = 19'h1 << 0;

    logic [18:0] stb;
    assign stb = {M, CIN, ABUS, SBUS, MBUS, DRW, LDC, LDZ, PCINC, LPC, PCADD,
                  LAR, ARINC, MEMW, LIR, SELCTL, STOP, SHORT, LONG};

    // {W, ST0, BUSY, RD_SEL, RS_SEL, S, strobes}
    logic [31:0] obs;
    assign obs = {W, ST0, BUSY, RD_SEL, RS_SEL, S, stb};

    typedef struct {
        string       nm;
        logic [31:0] v;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    function automatic void push(input string nm, input logic [2:0] w, input logic st0,
                                 input logic [1:0] rd, input logic [1:0] rs,
                                 input logic [3:0] s, input logic [18:0] st);
        exp_t e;
        e.nm = nm;
        e.v  = {w, st0, (w != 3'b000), rd, rs, s, st};
        sb.push_back(e);
    endfunction

    // Compare the current beat against the oldest expectation, then move to the next beat.
    task automatic check_beat();
        exp_t e;
        #1;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: observed=%h required=an expected entry", obs);
        end else begin
            e = sb.pop_front();
            if (obs !== e.v) begin
                errors++;
                $display("FAIL %s: observed=%h required=%h", e.nm, obs, e.v);
            end
        end
        @(negedge CLK);
    endtask

    task automatic check_idle(input string nm, input logic st0);
        push(nm, 3'b000, st0, 2'd0, 2'd0, 4'd0, 19'd0);
        check_beat();
    endtask

    task automatic pulse_start();
        @(negedge CLK);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
    endtask

    task automatic test_reset();
        CLR = 1'b1; START = 1'b0; SW = 3'b000; IR = 8'h00; C = 1'b0; Z = 1'b0;
        repeat (3) @(negedge CLK);
        CLR = 1'b0;
        for (int i = 0; i < 5; i++) check_idle("reset_idle", 1'b0);
    endtask

    task automatic test_write_regs();
        logic [1:0] r;
        SW = 3'b100;
        for (int p = 0; p < 4; p++) begin
            r = 2'((p % 2) * 2);
            push("wreg_b1", 3'b001, 1'(p % 2), r, 2'd0, 4'd0, B_SBUS | B_SEL | B_DRW | B_STOP);
            push("wreg_b2", 3'b010, 1'(p % 2), r + 2'd1, 2'd0, 4'd0, B_SBUS | B_SEL | B_DRW | B_STOP);
            pulse_start();
            check_beat();
            check_beat();
            check_idle("wreg_idle", 1'(1 - (p % 2)));
        end
    endtask

    task automatic test_mode_switch();
        // One more write pass leaves RIDX=2, ST0=1.
        push("wreg5_b1", 3'b001, 1'b0, 2'd0, 2'd0, 4'd0, B_SBUS | B_SEL | B_DRW | B_STOP);
        push("wreg5_b2", 3'b010, 1'b0, 2'd1, 2'd0, 4'd0, B_SBUS | B_SEL | B_DRW | B_STOP);
        pulse_start();
        check_beat(); check_beat();
        check_idle("wreg5_idle", 1'b1);
        SW = 3'b011;
        for (int p = 0; p < 3; p++) begin
            push("rreg_b1", 3'b001, 1'b0, 2'((p % 2) * 2), 2'((p % 2) * 2 + 1), 4'd0, B_SEL | B_STOP);
            push("rreg_b2", 3'b010, 1'b0, 2'((p % 2) * 2), 2'((p % 2) * 2 + 1), 4'd0, B_SEL | B_STOP);
            pulse_start();
            check_beat(); check_beat();
            check_idle("rreg_idle", 1'b0);
        end
    endtask

    task automatic test_mem_modes();
        SW = 3'b001;
        push("wmem_lar", 3'b001, 1'b0, 2'd0, 2'd0, 4'd0, B_SBUS | B_SEL | B_SHORT | B_STOP | B_LAR);
        pulse_start(); check_beat();
        check_idle("wmem_idle1", 1'b1);
        push("wmem_memw", 3'b001, 1'b1, 2'd0, 2'd0, 4'd0, B_SBUS | B_SEL | B_SHORT | B_STOP | B_MEMW | B_ARINC);
        pulse_start(); check_beat();
        check_idle("wmem_idle2", 1'b1);
        SW = 3'b010;
        push("rmem_lar", 3'b001, 1'b0, 2'd0, 2'd0, 4'd0, B_SBUS | B_SEL | B_SHORT | B_STOP | B_LAR);
        pulse_start(); check_beat();
        check_idle("rmem_idle1", 1'b1);
        push("rmem_mbus", 3'b001, 1'b1, 2'd0, 2'd0, 4'd0, B_SBUS | B_SEL | B_SHORT | B_STOP | B_MBUS | B_ARINC);
        pulse_start(); check_beat();
        check_idle("rmem_idle2", 1'b1);
    endtask

    // IR is changed at the negedge where the fetch beat is showing.
    task automatic fetch(input logic [7:0] ir);
        IR = ir;
        push("fetch_b1", 3'b001, 1'b1, ir[3:2], ir[1:0], 4'd0, B_LIR | B_PCINC);
        check_beat();
    endtask

    task automatic test_run();
        SW = 3'b000;
        push("pc_load", 3'b001, 1'b0, 2'd0, 2'd0, 4'd0, B_LPC | B_SBUS | B_SHORT | B_STOP);
        pulse_start(); check_beat();
        check_idle("pc_idle", 1'b1);
        IR = 8'b0101_01_10;
        pulse_start();
        fetch(8'b0101_01_10);
        push("ld_b2", 3'b010, 1'b1, 2'd1, 2'd2, 4'b1010, B_M | B_ABUS | B_LAR | B_LONG);
        push("ld_b3", 3'b100, 1'b1, 2'd1, 2'd2, 4'd0, B_DRW | B_MBUS);
        check_beat(); check_beat();
        fetch(8'b0001_10_11);
        push("add_b2", 3'b010, 1'b1, 2'd2, 2'd3, 4'b1001, B_CIN | B_ABUS | B_DRW | B_LDZ | B_LDC);
        check_beat();
        C = 1'b0;
        fetch(8'b0111_00_00);
        push("jc_c0", 3'b010, 1'b1, 2'd0, 2'd0, 4'd0, 19'd0);
        check_beat();
        C = 1'b1;
        fetch(8'b0111_00_00);
        push("jc_c1", 3'b010, 1'b1, 2'd0, 2'd0, 4'd0, B_PCADD);
        check_beat();
        Z = 1'b1;
        fetch(8'b1000_00_01);
        push("jz_z1", 3'b010, 1'b1, 2'd0, 2'd1, 4'd0, B_PCADD);
        check_beat();
        fetch(8'b1010_11_00);
        push("op1010_nop", 3'b010, 1'b1, 2'd3, 2'd0, 4'd0, 19'd0);
        check_beat();
        fetch(8'b1110_00_00);
        push("stp_b2", 3'b010, 1'b1, 2'd0, 2'd0, 4'd0, B_STOP);
        check_beat();
        for (int i = 0; i < 3; i++) check_idle("stp_hold", 1'b1);
    endtask

    task automatic test_clr_midbeat();
        IR = 8'b0011_01_01;
        pulse_start();
        fetch(8'b0011_01_01);
        push("and_b2", 3'b010, 1'b1, 2'd1, 2'd1, 4'b1011, B_M | B_ABUS | B_DRW | B_LDZ);
        #2;
        CLR = 1'b1;
        #1;
        checks++;
        if (obs !== 32'd0) begin
            errors++;
            $display("FAIL clr_midbeat: observed=%h required=%h", obs, 32'd0);
        end
        void'(sb.pop_back());
        @(negedge CLK);
        CLR = 1'b0;
        check_idle("after_clr", 1'b0);
        push("pc_load_after_clr", 3'b001, 1'b0, 2'd0, 2'd0, 4'd0, B_LPC | B_SBUS | B_SHORT | B_STOP);
        pulse_start(); check_beat();
        check_idle("after_clr_idle", 1'b1);
    endtask

    initial begin
        test_reset();
        test_write_regs();
        test_mode_switch();
        test_mem_modes();
        test_run();
        test_clr_midbeat();
        if (sb.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL scoreboard_leftover: observed=%0d entries required=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=still running required=finished");
        $fatal(1);
    end

endmodule
